// File: rtl/obstacle_sprite_ctrl.sv
// obstacle_sprite_ctrl: sprite RAM read addressing, chroma-keyed pixel pipeline and write-port arbitration with fill engine
module obstacle_sprite_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 2,
  parameter int KEY_IDX    = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic                  wr_reg,
  input  logic                  wr_ram,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_w,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [DATA_WIDTH-1:0] spr_idx,
  output logic                  spr_valid,
  output logic                  fill_busy
);
  localparam int H = ADDR_WIDTH / 2;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state;
  logic [10:0] x0, y0, xr, yr;
  logic enable, in_reg, in_reg_d1, fill_start, unused_ok;
  logic [DATA_WIDTH-1:0] fill_val;
  logic [ADDR_WIDTH-1:0] cnt;
  assign unused_ok  = ^wr_data[31:11];
  assign xr         = x - x0;
  assign yr         = y - y0;
  assign in_reg     = enable && (xr >> H) == 11'd0 && (yr >> H) == 11'd0;
  assign ram_addr_r = {yr[H-1:0], xr[H-1:0]};
  assign fill_start = wr_reg && addr[1:0] == 2'd2 && wr_data[1];
  assign fill_busy  = state == FILL;
  assign ram_we     = reset_n && (fill_busy || wr_ram);
  assign ram_addr_w = fill_busy ? cnt : addr;
  assign ram_din    = fill_busy ? fill_val : wr_data[DATA_WIDTH-1:0];
  // register readback, unused bits zero
  always_comb
    rd_data = addr[1:0] == 2'd0 ? {21'd0, x0} :
              addr[1:0] == 2'd1 ? {21'd0, y0} :
              addr[1:0] == 2'd2 ? 32'({fill_val, 1'b0, enable}) : {31'd0, fill_busy};
  // bus-writable position and enable registers, writable even while filling
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      x0     <= '0;
      y0     <= '0;
      enable <= 1'b0;
    end else if (wr_reg) begin
      if (addr[1:0] == 2'd0) x0 <= wr_data[10:0];
      if (addr[1:0] == 2'd1) y0 <= wr_data[10:0];
      if (addr[1:0] == 2'd2) enable <= wr_data[0];
    end
  // fill engine: sweeps every RAM address once, fill_val frozen for the whole sweep
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      fill_val <= '0;
    end else if (state == IDLE) begin
      if (fill_start) begin
        fill_val <= wr_data[2 +: DATA_WIDTH];
        cnt      <= '0;
        state    <= FILL;
      end
    end else begin
      cnt <= cnt + 1'b1;
      if (&cnt) state <= IDLE;
    end
  // two-stage pixel pipeline aligned with the registered RAM read
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      in_reg_d1 <= 1'b0;
      spr_idx   <= '0;
      spr_valid <= 1'b0;
    end else begin
      in_reg_d1 <= in_reg;
      spr_idx   <= ram_dout;
      spr_valid <= in_reg_d1 && ram_dout != DATA_WIDTH'(KEY_IDX);
    end
endmodule
